gpio_pad_ctrl: RTL and testbench

- Core-side controller for a bank of NPIN bidirectional mux pads.
- Turns register writes into per-pin pad control: data out, output enable, open-drain/open-source mode, pull-up/down, input enable.
- Samples each pad's Y input through a synchronizer and optional debounce filter, and raises a level interrupt on selected edges.
- Sits between the peripheral register bus and the pinmux pad ring.

---
 rtl/gpio_pad_pkg.sv | 32 +++
 rtl/gpio_pad_ctrl_in_filter.sv | 86 ++++++++
 rtl/gpio_pad_ctrl.sv | 175 +++++++++++++++++
 tb/tb_gpio_pad_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pad_pkg
//
// Shared constants for the GPIO pad controller bank:
//   - register index map (ADDR_DOUT .. ADDR_IRQ_STAT) and register count NREG
//   - default debounce length and debounce counter width
//
// Optional build macro used by the bank: GPIO_DEBOUNCE_EN (input debounce).
// -----------------------------------------------------------------------------
package gpio_pad_pkg;

  // Register indices, sized to match reg_addr so case items compare cleanly.
  localparam logic [3:0] ADDR_DOUT     = 4'd0;
  localparam logic [3:0] ADDR_OEN      = 4'd1;
  localparam logic [3:0] ADDR_ODM      = 4'd2;
  localparam logic [3:0] ADDR_OSM      = 4'd3;
  localparam logic [3:0] ADDR_PUE      = 4'd4;
  localparam logic [3:0] ADDR_PDE      = 4'd5;
  localparam logic [3:0] ADDR_IEN      = 4'd6;
  localparam logic [3:0] ADDR_DIN      = 4'd7;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'd8;
  localparam logic [3:0] ADDR_IRQ_POL  = 4'd9;
  localparam logic [3:0] ADDR_IRQ_STAT = 4'd10;

  // Number of implemented registers; indices NREG..15 read as zero.
  localparam int NREG = 11;

  // Debounce defaults: DB_CYCLES must stay within 1 .. 2**DBW-1.
  localparam int DB_CYCLES_DEF = 16;
  localparam int DBW_DEF       = 8;

endpackage : gpio_pad_pkg

// File: rtl/gpio_pad_ctrl_in_filter.sv
// -----------------------------------------------------------------------------
// gpio_in_filter
//
// Per-pin input conditioning for the GPIO bank:
//   pad_y -> 2-flop synchronizer -> (optional debounce) -> din -> din_q
// and edge detection between din and its one-cycle-delayed copy.
//
// Build option: GPIO_DEBOUNCE_EN
//   defined   : din only follows sync after sync has differed from din for
//               DB_CYCLES consecutive cycles (per-pin DBW-bit counter).
//   undefined : din = sync (2-cycle latency from pad_y).
//
// Ports:
//   clk, rst_n : bank clock, asynchronous active-low reset
//   pad_y      : raw pad input, asynchronous to clk
//   din        : filtered input level
//   rise, fall : single-cycle edge pulses on din (combinational from flops)
// -----------------------------------------------------------------------------
module gpio_in_filter #(
  parameter int DB_CYCLES = 16,
  parameter int DBW       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_y,
  output logic din,
  output logic rise,
  output logic fall
);

  logic sync_q1;
  logic sync_q2;
  logic din_q;

  // Two-stage synchronizer; pad_y has no timing relationship to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pad_y;
      sync_q2 <= sync_q1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [DBW-1:0] cnt_q;
  logic           din_r;

  // The counter measures how long sync has disagreed with din. Any cycle of
  // agreement restarts the count, so short glitches never reach din.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      din_r <= 1'b0;
    end else if (sync_q2 != din_r) begin
      if (cnt_q == DB_LAST) begin
        din_r <= sync_q2;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DBW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign din = din_r;
`else
  assign din = sync_q2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule : gpio_in_filter

// File: rtl/gpio_pad_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_pad_ctrl
//
// Core-side controller for NPIN bidirectional mux pads. Holds the register
// file, encodes per-pin pad controls (A, OE, OD, OS, PU, PD, IE), samples pad Y
// through one gpio_in_filter per pin and raises a registered level interrupt.
//
// Build option: GPIO_DEBOUNCE_EN enables the input debounce in gpio_in_filter.
//
// Register bus: reg_we is a single-cycle write strobe; reg_addr/reg_wdata are
// sampled on the clk edge where reg_we=1, with no back-pressure (always
// accepted). reg_rdata is combinational from reg_addr.
//
// Ports:
//   clk, rst_n             : bank clock, asynchronous active-low reset
//   reg_we/addr/wdata      : register write interface
//   reg_rdata              : register read data
//   pad_a/oe/od/os/pu/pd/ie: registered pad controls, one bit per pin
//   pad_y                  : pad inputs, asynchronous to clk
//   irq                    : registered level interrupt
// -----------------------------------------------------------------------------
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int NPIN      = 8,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DBW       = DBW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reg_we,
  input  logic [3:0]      reg_addr,
  input  logic [NPIN-1:0] reg_wdata,
  output logic [NPIN-1:0] reg_rdata,
  output logic [NPIN-1:0] pad_a,
  output logic [NPIN-1:0] pad_oe,
  output logic [NPIN-1:0] pad_od,
  output logic [NPIN-1:0] pad_os,
  output logic [NPIN-1:0] pad_pu,
  output logic [NPIN-1:0] pad_pd,
  output logic [NPIN-1:0] pad_ie,
  input  logic [NPIN-1:0] pad_y,
  output logic            irq
);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [NPIN-1:0] dout_q;
  logic [NPIN-1:0] oen_q;
  logic [NPIN-1:0] odm_q;
  logic [NPIN-1:0] osm_q;
  logic [NPIN-1:0] pue_q;
  logic [NPIN-1:0] pde_q;
  logic [NPIN-1:0] ien_q;
  logic [NPIN-1:0] irq_en_q;
  logic [NPIN-1:0] irq_pol_q;
  logic [NPIN-1:0] irq_stat_q;

  logic [NPIN-1:0] din;
  logic [NPIN-1:0] rise;
  logic [NPIN-1:0] fall;
  logic [NPIN-1:0] stat_set;
  logic [NPIN-1:0] stat_clr;

  // Plain read/write registers. DIN, IRQ_STAT and unmapped indices are not
  // written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q    <= '0;
      oen_q     <= '0;
      odm_q     <= '0;
      osm_q     <= '0;
      pue_q     <= '0;
      pde_q     <= '0;
      ien_q     <= '0;
      irq_en_q  <= '0;
      irq_pol_q <= '0;
    end else if (reg_we) begin
      case (reg_addr)
        ADDR_DOUT:    dout_q    <= reg_wdata;
        ADDR_OEN:     oen_q     <= reg_wdata;
        ADDR_ODM:     odm_q     <= reg_wdata;
        ADDR_OSM:     osm_q     <= reg_wdata;
        ADDR_PUE:     pue_q     <= reg_wdata;
        ADDR_PDE:     pde_q     <= reg_wdata;
        ADDR_IEN:     ien_q     <= reg_wdata;
        ADDR_IRQ_EN:  irq_en_q  <= reg_wdata;
        ADDR_IRQ_POL: irq_pol_q <= reg_wdata;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt status: W1C, with a same-cycle set taking priority over clear.
  // Disabling IRQ_EN masks new sets and irq, but leaves pending status alone.
  // ---------------------------------------------------------------------------
  assign stat_clr = (reg_we && (reg_addr == ADDR_IRQ_STAT)) ? reg_wdata : '0;
  assign stat_set = irq_en_q & ((irq_pol_q & rise) | (~irq_pol_q & fall));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_stat_q <= '0;
      irq        <= 1'b0;
    end else begin
      irq_stat_q <= (irq_stat_q & ~stat_clr) | stat_set;
      irq        <= |(irq_stat_q & irq_en_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Pad encoding. ODM and OSM both set is meaningless, so it falls back to
  // push-pull; conflicting pulls resolve to pull-up.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_a  <= '0;
      pad_oe <= '0;
      pad_od <= '0;
      pad_os <= '0;
      pad_pu <= '0;
      pad_pd <= '0;
      pad_ie <= '0;
    end else begin
      pad_a  <= dout_q;
      pad_oe <= oen_q;
      pad_od <= odm_q & ~osm_q;
      pad_os <= osm_q & ~odm_q;
      pad_pu <= pue_q;
      pad_pd <= pde_q & ~pue_q;
      pad_ie <= ien_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Input path: one filter per pin. A pad with IE low drives Y=0 itself, so
  // no gating by IEN is needed here.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NPIN; i++) begin : g_pin
    gpio_in_filter #(
      .DB_CYCLES (DB_CYCLES),
      .DBW       (DBW)
    ) u_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .pad_y (pad_y[i]),
      .din   (din[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_DOUT:     reg_rdata = dout_q;
      ADDR_OEN:      reg_rdata = oen_q;
      ADDR_ODM:      reg_rdata = odm_q;
      ADDR_OSM:      reg_rdata = osm_q;
      ADDR_PUE:      reg_rdata = pue_q;
      ADDR_PDE:      reg_rdata = pde_q;
      ADDR_IEN:      reg_rdata = ien_q;
      ADDR_DIN:      reg_rdata = din;
      ADDR_IRQ_EN:   reg_rdata = irq_en_q;
      ADDR_IRQ_POL:  reg_rdata = irq_pol_q;
      ADDR_IRQ_STAT: reg_rdata = irq_stat_q;
      default:       reg_rdata = '0;
    endcase
  end

endmodule : gpio_pad_ctrl

// File: tb/tb_gpio_pad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_pad_ctrl
//
// Directed bench for gpio_pad_ctrl. Inputs change and outputs are sampled on
// the falling clock edge; the design acts on the rising edge. The pad model
// returns Y=0 for any pin whose pad_ie is low. Latency expectations follow
// GPIO_DEBOUNCE_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_gpio_pad_ctrl;
  import gpio_pad_pkg::*;

  localparam int NPIN = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + DB_CYCLES_DEF;
`else
  localparam int LAT = 2;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            reg_we;
  logic [3:0]      reg_addr;
  logic [NPIN-1:0] reg_wdata;
  logic [NPIN-1:0] reg_rdata;
  logic [NPIN-1:0] pad_a;
  logic [NPIN-1:0] pad_oe;
  logic [NPIN-1:0] pad_od;
  logic [NPIN-1:0] pad_os;
  logic [NPIN-1:0] pad_pu;
  logic [NPIN-1:0] pad_pd;
  logic [NPIN-1:0] pad_ie;
  logic [NPIN-1:0] pad_y;
  logic [NPIN-1:0] y_src;
  logic            irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Pad model: input buffer disabled means Y reads 0.
  assign pad_y = y_src & pad_ie;

  gpio_pad_ctrl #(
    .NPIN      (NPIN),
    .DB_CYCLES (DB_CYCLES_DEF),
    .DBW       (DBW_DEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .pad_a     (pad_a),
    .pad_oe    (pad_oe),
    .pad_od    (pad_od),
    .pad_os    (pad_os),
    .pad_pu    (pad_pu),
    .pad_pd    (pad_pd),
    .pad_ie    (pad_ie),
    .pad_y     (pad_y),
    .irq       (irq)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; the write lands on the next rising edge and the
  // task returns on the falling edge after it.
  task automatic wr(input logic [3:0] a, input logic [NPIN-1:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    reg_we    = 1'b0;
    reg_wdata = '0;
    reg_addr  = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [NPIN-1:0] exp);
    reg_addr = a;
    #1;
    chk(tag, 32'(reg_rdata), 32'(exp));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b1;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    y_src     = '0;
    #2 rst_n  = 1'b0;
    tick(3);

    // Reset state
    chk("rst_pad_oe", 32'(pad_oe), 32'h0);
    chk("rst_pad_a",  32'(pad_a),  32'h0);
    chk("rst_pad_ie", 32'(pad_ie), 32'h0);
    chk("rst_pad_pu", 32'(pad_pu), 32'h0);
    chk("rst_irq",    32'(irq),    32'h0);
    rst_n = 1'b1;
    tick(1);

    // Illegal OD+OS collapses to push-pull; pull-up wins a pull conflict.
    wr(ADDR_ODM, 8'h01);
    wr(ADDR_OSM, 8'h01);
    wr(ADDR_PUE, 8'h02);
    wr(ADDR_PDE, 8'h02);
    tick(1);
    chk("conf_od", 32'(pad_od), 32'h00);
    chk("conf_os", 32'(pad_os), 32'h00);
    chk("conf_pu", 32'(pad_pu), 32'h02);
    chk("conf_pd", 32'(pad_pd), 32'h00);
    chk("conf_a",  32'(pad_a),  32'h00);
    chk("conf_oe", 32'(pad_oe), 32'h00);
    chk_reg("rd_odm",   ADDR_ODM, 8'h01);
    chk_reg("rd_pde",   ADDR_PDE, 8'h02);
    chk_reg("rd_unmap", 4'd12,    8'h00);
    wr(4'd12, 8'hFF);
    wr(ADDR_DIN, 8'hFF);
    chk_reg("rd_unmap_wr", 4'd12,    8'h00);
    chk_reg("rd_din_wr",   ADDR_DIN, 8'h00);

    // Output registers, one cycle of pad latency after the write edge.
    tick(1);
    wr(ADDR_DOUT, 8'hA5);
    chk("dout_early", 32'(pad_a), 32'h00);
    tick(1);
    chk("dout_pad", 32'(pad_a), 32'hA5);
    wr(ADDR_OEN, 8'hFF);
    chk("oen_early", 32'(pad_oe), 32'h00);
    tick(1);
    chk("oen_pad", 32'(pad_oe), 32'hFF);
    wr(ADDR_OSM, 8'h00);
    wr(ADDR_ODM, 8'h0F);
    tick(1);
    chk("odm_pad", 32'(pad_od), 32'h0F);
    chk("osm_pad", 32'(pad_os), 32'h00);

    // Rising edge interrupt on pin 0.
    wr(ADDR_IEN,     8'h01);
    wr(ADDR_IRQ_EN,  8'h01);
    wr(ADDR_IRQ_POL, 8'h01);
    tick(1);
    chk("ie_pad", 32'(pad_ie), 32'h01);
    y_src = 8'h01;
    tick(LAT - 1);
    chk_reg("din_before", ADDR_DIN, 8'h00);
    tick(1);
    chk_reg("din_after", ADDR_DIN, 8'h01);
    chk("irq_before_stat", 32'(irq), 32'h0);
    tick(1);
    chk_reg("stat_set", ADDR_IRQ_STAT, 8'h01);
    chk("irq_lag", 32'(irq), 32'h0);
    tick(1);
    chk("irq_set", 32'(irq), 32'h1);

    // W1C clears status, irq drops one cycle later.
    wr(ADDR_IRQ_STAT, 8'h01);
    chk_reg("stat_w1c", ADDR_IRQ_STAT, 8'h00);
    tick(1);
    chk("irq_w1c", 32'(irq), 32'h0);

    // Falling edge with rising polarity sets nothing.
    y_src = 8'h00;
    tick(LAT + 3);
    chk_reg("din_fall", ADDR_DIN, 8'h00);
    chk_reg("stat_nofall", ADDR_IRQ_STAT, 8'h00);

    // W1C in the same cycle as a new set: set wins.
    y_src = 8'h01;
    tick(LAT);
    wr(ADDR_IRQ_STAT, 8'h01);
    chk_reg("stat_set_wins", ADDR_IRQ_STAT, 8'h01);
    tick(1);
    chk("irq_set_wins", 32'(irq), 32'h1);

    // Clearing the enable masks irq but keeps status.
    wr(ADDR_IRQ_EN, 8'h00);
    chk_reg("stat_keep", ADDR_IRQ_STAT, 8'h01);
    tick(1);
    chk("irq_masked", 32'(irq), 32'h0);

    // Falling polarity on pin 1; pin 2 has IE low so it reads 0.
    wr(ADDR_IEN,    8'h03);
    wr(ADDR_IRQ_EN, 8'h02);
    y_src = 8'h07;
    tick(LAT + 3);
    chk_reg("din_gate", ADDR_DIN, 8'h03);
    chk_reg("stat_norise1", ADDR_IRQ_STAT, 8'h01);
    y_src = 8'h05;
    tick(LAT + 1);
    chk_reg("stat_fall1", ADDR_IRQ_STAT, 8'h03);
    chk("irq_fall_lag", 32'(irq), 32'h0);
    tick(1);
    chk("irq_fall", 32'(irq), 32'h1);

    // Clear all, then pin 3 rising edge.
    wr(ADDR_IRQ_STAT, 8'hFF);
    tick(1);
    chk("irq_clr_all", 32'(irq), 32'h0);
    wr(ADDR_IEN,     8'h0F);
    wr(ADDR_IRQ_EN,  8'h08);
    wr(ADDR_IRQ_POL, 8'h08);
    tick(LAT + 2);
    chk_reg("din_pin2_on", ADDR_DIN, 8'h05);
`ifdef GPIO_DEBOUNCE_EN
    // A 10-cycle glitch is shorter than the debounce window.
    y_src = 8'h0D;
    tick(10);
    y_src = 8'h05;
    tick(30);
    chk_reg("glitch_din", ADDR_DIN, 8'h05);
    chk_reg("glitch_stat", ADDR_IRQ_STAT, 8'h00);
    chk("glitch_irq", 32'(irq), 32'h0);
`endif
    y_src = 8'h0D;
    tick(LAT - 1);
    chk_reg("hold_before", ADDR_DIN, 8'h05);
    tick(1);
    chk_reg("hold_after", ADDR_DIN, 8'h0D);
    tick(1);
    chk_reg("stat_pin3", ADDR_IRQ_STAT, 8'h08);
    tick(1);
    chk("irq_pin3", 32'(irq), 32'h1);

    // Asynchronous reset mid-operation releases the pads at once.
    y_src = 8'h05;
    tick(5);
    chk("pre_rst_oe", 32'(pad_oe), 32'hFF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_oe",  32'(pad_oe), 32'h00);
    chk("async_rst_od",  32'(pad_od), 32'h00);
    chk("async_rst_irq", 32'(irq),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_reg("post_rst_din",  ADDR_DIN,      8'h00);
    chk_reg("post_rst_stat", ADDR_IRQ_STAT, 8'h00);
    chk_reg("post_rst_oen",  ADDR_OEN,      8'h00);
    tick(1);
    wr(ADDR_IEN, 8'h08);
    tick(1);
    y_src = 8'h08;
`ifdef GPIO_DEBOUNCE_EN
    // One cycle short of the window: no change.
    tick(DB_CYCLES_DEF - 1);
    y_src = 8'h00;
    tick(25);
    chk_reg("post_rst_short", ADDR_DIN, 8'h00);
`else
    tick(LAT);
    chk_reg("post_rst_path", ADDR_DIN, 8'h08);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_gpio_pad_ctrl
